// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the divide sequencing controller and its helpers:
//   - operand / register-index widths
//   - RISC-V M-extension divide function encodings
//   - controller state encoding (legacy-compatible localparam constants)
//   - INT_MIN / ALL_ONES constants used by the corner-case rules
//   - latched request record
// ---------------------------------------------------------------------------
package div_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // func_i encodings: bit 0 selects unsigned, bit 1 selects remainder
  localparam logic [1:0] FUNC_DIV  = 2'b00;
  localparam logic [1:0] FUNC_DIVU = 2'b01;
  localparam logic [1:0] FUNC_REM  = 2'b10;
  localparam logic [1:0] FUNC_REMU = 2'b11;

  // Controller states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

  // Operands and destination captured when a request is accepted
  typedef struct packed {
    logic [XLEN-1:0]       operand_a;
    logic [XLEN-1:0]       operand_b;
    logic [1:0]            func;
    logic [REG_ADDR_W-1:0] rd_addr;
  } div_req_t;

  // DIV and REM interpret operands as two's complement
  function automatic logic func_is_signed(input logic [1:0] func);
    return ~func[0];
  endfunction

  // REM and REMU return the remainder instead of the quotient
  function automatic logic func_is_rem(input logic [1:0] func);
    return func[1];
  endfunction

endpackage : div_pkg

// File: rtl/div_special_case.sv
// ---------------------------------------------------------------------------
// div_special_case
// Combinational detection of the RISC-V divide corner cases and the
// architecturally defined result for each, so they never reach the divider.
//   i_operand_a  dividend
//   i_operand_b  divisor
//   i_func       DIV/DIVU/REM/REMU encoding
//   o_special    1 when the operation is divide-by-zero or signed overflow
//   o_result     defined result for the corner case (0 when not special)
// ---------------------------------------------------------------------------
module div_special_case
  import div_pkg::*;
(
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  input  logic [1:0]      i_func,
  output logic            o_special,
  output logic [XLEN-1:0] o_result
);

  logic w_div_by_zero;
  logic w_overflow;

  // Corner-case detect and result select
  always_comb begin
    w_div_by_zero = (i_operand_b == {XLEN{1'b0}});
    // Only the signed forms overflow: INT_MIN / -1 does not fit in XLEN bits
    w_overflow    = func_is_signed(i_func) &&
                    (i_operand_a == INT_MIN) &&
                    (i_operand_b == ALL_ONES);
    o_special     = w_div_by_zero || w_overflow;

    if (w_div_by_zero) begin
      // Quotient saturates to all ones; remainder is the dividend itself
      if (func_is_rem(i_func)) begin
        o_result = i_operand_a;
      end else begin
        o_result = ALL_ONES;
      end
    end else if (w_overflow) begin
      // Quotient wraps to INT_MIN; remainder is zero
      if (func_is_rem(i_func)) begin
        o_result = {XLEN{1'b0}};
      end else begin
        o_result = INT_MIN;
      end
    end else begin
      o_result = {XLEN{1'b0}};
    end
  end

endmodule : div_special_case

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl
// Sequencer between the EX stage and the multi-cycle divider datapath.
// Accepts one divide-class request at a time, resolves divide-by-zero and
// signed overflow locally, otherwise issues one start pulse and holds the
// divider operands until the result returns. Stalls the pipeline while busy
// and discards in-flight results when the instruction is flushed.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i                EX stage holds a divide-class instruction
//   operand_a_i/_b_i     dividend / divisor
//   func_i               00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rd_addr_i            destination register of the request
//   flush_i              kill the current instruction
//   stall_o              hold IF/ID/EX
//   result_valid_o       one-cycle writeback strobe
//   result_o, rd_addr_o  registered result and its destination
//   div_start_o          single-cycle start pulse to the divider
//   div_operand_a_o/_b_o latched divider operands
//   div_func_o           latched divider function
//   div_result_i         divider result
//   div_done_i           divider result valid
// ---------------------------------------------------------------------------
module div_ctrl
  import div_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [XLEN-1:0]       operand_a_i,
  input  logic [XLEN-1:0]       operand_b_i,
  input  logic [1:0]            func_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  result_valid_o,
  output logic [XLEN-1:0]       result_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  div_start_o,
  output logic [XLEN-1:0]       div_operand_a_o,
  output logic [XLEN-1:0]       div_operand_b_o,
  output logic [1:0]            div_func_o,
  input  logic [XLEN-1:0]       div_result_i,
  input  logic                  div_done_i
);

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  div_req_t              r_req;
  logic [XLEN-1:0]       r_result;
  logic [REG_ADDR_W-1:0] r_rd_out;

  logic                  w_accept;
  logic                  w_cap_special;
  logic                  w_cap_div;
  logic                  w_special;
  logic [XLEN-1:0]       w_special_result;

  // Corner cases are judged on the live request so they finish in one cycle
  div_special_case u_special (
    .i_operand_a (operand_a_i),
    .i_operand_b (operand_b_i),
    .i_func      (func_i),
    .o_special   (w_special),
    .o_result    (w_special_result)
  );

  // Next-state and capture decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_cap_special = 1'b0;
    w_cap_div     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_i && !flush_i) begin
          w_accept = 1'b1;
          if (w_special) begin
            w_cap_special = 1'b1;
            w_state_nxt   = ST_DONE;
          end else begin
            w_state_nxt   = ST_ISSUE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // A flush here means the start pulse is suppressed, so nothing to drain
        if (flush_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (div_done_i) begin
          if (flush_i) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_cap_div   = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end else if (flush_i) begin
          // Divider cannot be aborted; wait out its result before reissuing
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (div_done_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        // req_i here is still the completing instruction, never a new one
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs follow the current state and the same-cycle flush
  always_comb begin
    stall_o        = req_i && (r_state != ST_DONE);
    div_start_o    = (r_state == ST_ISSUE) && !flush_i;
    result_valid_o = (r_state == ST_DONE) && !flush_i;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request latch; holds divider operands stable until the next acceptance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req <= '{operand_a: {XLEN{1'b0}}, operand_b: {XLEN{1'b0}},
                 func: 2'b00, rd_addr: {REG_ADDR_W{1'b0}}};
    end else if (w_accept) begin
      r_req <= '{operand_a: operand_a_i, operand_b: operand_b_i,
                 func: func_i, rd_addr: rd_addr_i};
    end else begin
      r_req <= r_req;
    end
  end

  // Result register; keeps its last value between writebacks
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_result <= {XLEN{1'b0}};
      r_rd_out <= {REG_ADDR_W{1'b0}};
    end else if (w_cap_special) begin
      r_result <= w_special_result;
      r_rd_out <= rd_addr_i;
    end else if (w_cap_div) begin
      r_result <= div_result_i;
      r_rd_out <= r_req.rd_addr;
    end else begin
      r_result <= r_result;
      r_rd_out <= r_rd_out;
    end
  end

  assign result_o        = r_result;
  assign rd_addr_o       = r_rd_out;
  assign div_operand_a_o = r_req.operand_a;
  assign div_operand_b_o = r_req.operand_b;
  assign div_func_o      = r_req.func;

endmodule : div_ctrl

// File: tb/tb_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_ctrl
// Self-checking bench for div_ctrl: a directed vector table, hand-written
// flush/reset sequences and randomized operations against an arithmetic
// reference model. A small divider model answers start pulses after a
// programmable delay.
// ---------------------------------------------------------------------------
module tb_div_ctrl;
  import div_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_ni;
  logic                  req_i;
  logic [XLEN-1:0]       operand_a_i;
  logic [XLEN-1:0]       operand_b_i;
  logic [1:0]            func_i;
  logic [REG_ADDR_W-1:0] rd_addr_i;
  logic                  flush_i;
  logic                  stall_o;
  logic                  result_valid_o;
  logic [XLEN-1:0]       result_o;
  logic [REG_ADDR_W-1:0] rd_addr_o;
  logic                  div_start_o;
  logic [XLEN-1:0]       div_operand_a_o;
  logic [XLEN-1:0]       div_operand_b_o;
  logic [1:0]            div_func_o;
  logic [XLEN-1:0]       div_result_i;
  logic                  div_done_i;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .req_i           (req_i),
    .operand_a_i     (operand_a_i),
    .operand_b_i     (operand_b_i),
    .func_i          (func_i),
    .rd_addr_i       (rd_addr_i),
    .flush_i         (flush_i),
    .stall_o         (stall_o),
    .result_valid_o  (result_valid_o),
    .result_o        (result_o),
    .rd_addr_o       (rd_addr_o),
    .div_start_o     (div_start_o),
    .div_operand_a_o (div_operand_a_o),
    .div_operand_b_o (div_operand_b_o),
    .div_func_o      (div_func_o),
    .div_result_i    (div_result_i),
    .div_done_i      (div_done_i)
  );

  // Reference: RISC-V divide semantics using magnitudes and plain arithmetic
  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] f);
    logic [31:0] ma, mb, q, r;
    logic sgn;
    sgn = ~f[0];
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (f[1]) return (sgn && a[31]) ? -r : r;
    return (sgn && (a[31] ^ b[31])) ? -q : q;
  endfunction

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b,
                                    input logic [1:0] f);
    return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Divider model: result appears div_lat+2 cycles after the start cycle;
  // a divide by zero returns garbage so a wrongly issued special case shows
  int          div_lat = 0;
  int          m_cnt;
  logic        m_busy;
  int          m_overlap = 0;
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      div_done_i   <= 1'b0;
      div_result_i <= 32'd0;
      m_busy       <= 1'b0;
      m_cnt        <= 0;
    end else begin
      div_done_i <= 1'b0;
      if (div_start_o) begin
        if (m_busy) m_overlap <= m_overlap + 1;
        m_busy <= 1'b1;
        m_cnt  <= div_lat;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          div_done_i   <= 1'b1;
          div_result_i <= (div_operand_b_o == 32'd0) ? 32'hDEAD_BEEF
                          : ref_result(div_operand_a_o, div_operand_b_o, div_func_o);
          m_busy       <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                       input logic [4:0] rd);
    req_i = 1'b1; operand_a_i = a; operand_b_i = b; func_i = f; rd_addr_i = rd;
  endtask

  // One full request from acceptance to writeback, checked cycle by cycle
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                       input logic [4:0] rd, input int lat, input logic [31:0] exp);
    int c, starts, exp_lat;
    bit seen, spc;
    spc     = is_special(a, b, f);
    exp_lat = spc ? 1 : 4 + lat;
    cyc();
    div_lat = lat; flush_i = 1'b0;
    drive(a, b, f, rd);
    @(negedge clk);
    chk("accept_stall", stall_o, 1);
    chk("accept_valid", result_valid_o, 0);
    chk("accept_start", div_start_o, 0);
    c = 0; starts = 0; seen = 0;
    while (!seen && c < 40) begin
      cyc();
      c++;
      @(negedge clk);
      if (div_start_o) begin
        starts++;
        chk("start_cycle", c, 1);
      end
      if (result_valid_o) seen = 1;
      else chk("busy_stall", stall_o, 1);
    end
    chk("valid_seen", seen, 1);
    chk("latency", c, exp_lat);
    chk("result", result_o, exp);
    chk("rd_addr", rd_addr_o, rd);
    chk("done_stall", stall_o, 0);
    chk("start_count", starts, spc ? 0 : 1);
  endtask

  task automatic idle();
    cyc();
    req_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  f;
    logic [4:0]  rd;
    int          lat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c, start_at, valid_at;
    bit seen;
    logic [31:0] a, b;

    // Directed table (0xFFFFFFEF/5 = 0x3333332F r 4; 0xFFFFFFF1/5 = 0x33333330 r 1)
    vecs[0]  = '{32'hFFFF_FFF1, 32'd5,         FUNC_DIV,  5'd1,  0, 32'hFFFF_FFFD};
    vecs[1]  = '{32'hFFFF_FFEF, 32'd5,         FUNC_DIVU, 5'd2,  0, 32'h3333_332F};
    vecs[2]  = '{32'hFFFF_FFEF, 32'd5,         FUNC_REMU, 5'd3,  0, 32'h0000_0004};
    vecs[3]  = '{32'hFFFF_FFF1, 32'd5,         FUNC_DIVU, 5'd4,  1, 32'h3333_3330};
    vecs[4]  = '{32'hFFFF_FFF1, 32'd5,         FUNC_REMU, 5'd5,  0, 32'h0000_0001};
    vecs[5]  = '{32'hFFFF_FFF1, 32'd0,         FUNC_REM,  5'd6,  0, 32'hFFFF_FFF1};
    vecs[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, FUNC_DIV,  5'd7,  0, 32'h8000_0000};
    vecs[7]  = '{32'h8000_0000, 32'hFFFF_FFFF, FUNC_REM,  5'd8,  0, 32'h0000_0000};
    vecs[8]  = '{32'd7,         32'd0,         FUNC_DIVU, 5'd9,  0, 32'hFFFF_FFFF};
    vecs[9]  = '{32'h8000_0000, 32'hFFFF_FFFF, FUNC_DIVU, 5'd10, 2, 32'h0000_0000};
    vecs[10] = '{32'hFFFF_FFF1, 32'd4,         FUNC_REM,  5'd11, 0, 32'hFFFF_FFFD};
    vecs[11] = '{32'd20,        32'd4,         FUNC_DIV,  5'd12, 3, 32'd5};

    rst_ni = 1'b0; req_i = 1'b0; flush_i = 1'b0;
    operand_a_i = 32'd0; operand_b_i = 32'd0; func_i = 2'b00; rd_addr_i = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_valid", result_valid_o, 0);
    chk("rst_start", div_start_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_rd", rd_addr_o, 0);
    chk("rst_opa", div_operand_a_o, 0);
    chk("rst_opb", div_operand_b_o, 0);
    chk("rst_func", div_func_o, 0);
    rst_ni = 1'b1;

    // Table, back-to-back
    for (int i = 0; i < 12; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].rd, vecs[i].lat, vecs[i].exp);
    idle();

    // Flush in cycle 2 of DIV 100/7, new request held through DRAIN
    cyc(); div_lat = 2; flush_i = 1'b0; drive(32'd100, 32'd7, FUNC_DIV, 5'd3); @(negedge clk);
    cyc(); @(negedge clk); chk("drn_start_c1", div_start_o, 1);
    cyc(); flush_i = 1'b1; @(negedge clk);
    chk("drn_valid_c2", result_valid_o, 0);
    chk("drn_stall_c2", stall_o, 1);
    cyc(); flush_i = 1'b0; div_lat = 0; drive(32'd14, 32'd3, FUNC_DIV, 5'd4); @(negedge clk);
    c = 3; start_at = -1; valid_at = -1; seen = 0;
    while (!seen && c < 40) begin
      if (div_start_o) start_at = c;
      if (result_valid_o) begin
        seen = 1; valid_at = c;
      end else begin
        chk("drn_stall", stall_o, 1);
        cyc(); c++; @(negedge clk);
      end
    end
    chk("drn_start_at", start_at, 7);
    chk("drn_valid_at", valid_at, 10);
    chk("drn_result", result_o, 4);
    chk("drn_rd", rd_addr_o, 4);
    idle();

    // Flush coincident with ISSUE
    cyc(); div_lat = 0; drive(32'd9, 32'd2, FUNC_DIVU, 5'd5); @(negedge clk);
    cyc(); flush_i = 1'b1; @(negedge clk); chk("fiss_start", div_start_o, 0);
    cyc(); flush_i = 1'b0; req_i = 1'b0; @(negedge clk);
    chk("fiss_start2", div_start_o, 0);
    chk("fiss_valid", result_valid_o, 0);
    do_op(32'd9, 32'd2, FUNC_DIVU, 5'd5, 0, 32'd4);
    idle();

    // Flush coincident with divider done: result dropped
    cyc(); div_lat = 0; drive(32'd50, 32'd5, FUNC_DIVU, 5'd6); @(negedge clk);
    cyc(); @(negedge clk);
    cyc(); @(negedge clk);
    cyc(); flush_i = 1'b1; @(negedge clk); chk("fdone_valid_c3", result_valid_o, 0);
    cyc(); flush_i = 1'b0; req_i = 1'b0; @(negedge clk); chk("fdone_valid_c4", result_valid_o, 0);
    do_op(32'd50, 32'd5, FUNC_REMU, 5'd6, 0, 32'd0);

    // Flush in DONE suppresses the strobe
    cyc(); div_lat = 0; drive(32'd20, 32'd4, FUNC_DIV, 5'd7); @(negedge clk);
    repeat (3) begin cyc(); @(negedge clk); end
    cyc(); flush_i = 1'b1; @(negedge clk);
    chk("fdn_valid", result_valid_o, 0);
    chk("fdn_stall", stall_o, 0);
    cyc(); flush_i = 1'b0; req_i = 1'b0; @(negedge clk); chk("fdn_valid2", result_valid_o, 0);
    do_op(32'd21, 32'd4, FUNC_REM, 5'd8, 1, 32'd1);

    // Asynchronous reset while waiting on the divider
    cyc(); div_lat = 3; drive(32'd100, 32'd7, FUNC_DIV, 5'd9); @(negedge clk);
    cyc(); @(negedge clk);
    cyc(); rst_ni = 1'b0; req_i = 1'b0; #1;
    chk("arst_stall", stall_o, 0);
    chk("arst_valid", result_valid_o, 0);
    chk("arst_start", div_start_o, 0);
    chk("arst_result", result_o, 0);
    chk("arst_rd", rd_addr_o, 0);
    chk("arst_opa", div_operand_a_o, 0);
    chk("arst_opb", div_operand_b_o, 0);
    chk("arst_func", div_func_o, 0);
    cyc(); cyc(); rst_ni = 1'b1;
    do_op(32'd20, 32'd4, FUNC_DIV, 5'd10, 0, 32'd5);

    // Randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'd0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 9);
        default: b = $urandom;
      endcase
      begin
        logic [1:0] f;
        f = 2'($urandom_range(0, 3));
        do_op(a, b, f, 5'($urandom_range(0, 31)), $urandom_range(0, 3), ref_result(a, b, f));
      end
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    chk("divider_overlap", m_overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_div_ctrl
